// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the 8-entry register file: round-robin sharing of the
// single write port among NREQ requesters, plus a hardware clear of all registers.
module regfile_write_scheduler #(
    parameter int DATA_W = 8,
    parameter int NREQ   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [3*NREQ-1:0]      req_addr,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    input  logic                   clr_start,
    output logic                   clr_busy,
    output logic [2:0]             dec_sel,
    output logic                   dec_en,
    output logic [DATA_W-1:0]      wr_data
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [2:0]          cnt_r, cnt_s;
    logic [IDX_W-1:0]    ptr_r, ptr_s;
    logic [NREQ-1:0]     ack_r, ack_s;
    logic                busy_r, busy_s;
    logic [2:0]          sel_r, sel_s;
    logic                en_r, en_s;
    logic [DATA_W-1:0]   data_r, data_s;

    logic [NREQ-1:0]     elig_s;
    logic [IDX_W-1:0]    win_s;
    logic                found_s;
    logic                clr_run_s;
    logic                clr_ok_s;

    // Round-robin search from ptr+1; the requester acked this cycle sits out.
    always_comb begin
        elig_s  = req & ~ack_r;
        found_s = 1'b0;
        win_s   = {IDX_W{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_s && elig_s[(int'(ptr_r) + k) % NREQ]) begin
                found_s = 1'b1;
                win_s   = IDX_W'((int'(ptr_r) + k) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s = IDLE;
        cnt_s   = 3'd0;
        ptr_s   = ptr_r;
        ack_s   = {NREQ{1'b0}};
        busy_s  = 1'b0;
        sel_s   = 3'd0;
        en_s    = 1'b0;
        data_s  = {DATA_W{1'b0}};

        // The last clear step doubles as an arbitration point, but a new clear cannot start there.
        case (state_r)
            IDLE, WRITE: begin
                clr_run_s = 1'b0;
                clr_ok_s  = 1'b1;
            end
            CLEAR: begin
                clr_run_s = (cnt_r != 3'd7);
                clr_ok_s  = 1'b0;
            end
            default: begin
                clr_run_s = 1'b0;
                clr_ok_s  = 1'b1;
            end
        endcase

        if (clr_run_s) begin
            state_s = CLEAR;
            cnt_s   = cnt_r + 3'd1;
            busy_s  = 1'b1;
            en_s    = 1'b1;
            sel_s   = cnt_r + 3'd1;
        end else if (clr_ok_s && clr_start) begin
            state_s = CLEAR;
            cnt_s   = 3'd0;
            busy_s  = 1'b1;
            en_s    = 1'b1;
            sel_s   = 3'd0;
        end else if (found_s) begin
            state_s = WRITE;
            en_s    = 1'b1;
            sel_s   = req_addr[int'(win_s)*3 +: 3];
            data_s  = req_data[int'(win_s)*DATA_W +: DATA_W];
            ack_s   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            ptr_s   = win_s;
        end else begin
            state_s = IDLE;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            ptr_r   <= PTR_RST;
            ack_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            sel_r   <= 3'd0;
            en_r    <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ptr_r   <= ptr_s;
            ack_r   <= ack_s;
            busy_r  <= busy_s;
            sel_r   <= sel_s;
            en_r    <= en_s;
            data_r  <= data_s;
        end
    end

    assign ack      = ack_r;
    assign clr_busy = busy_r;
    assign dec_sel  = sel_r;
    assign dec_en   = en_r;
    assign wr_data  = data_r;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed, table-driven bench for regfile_write_scheduler (NREQ=4, DATA_W=8).
module tb_regfile_write_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        clr_start;
    logic        clr_busy;
    logic [2:0]  dec_sel;
    logic        dec_en;
    logic [7:0]  wr_data;

    int total;
    int bad;

    typedef struct {
        logic [3:0] req;
        logic       clr;
        logic [3:0] ack;
        logic       en;
        logic [2:0] sel;
        logic [7:0] dat;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    regfile_write_scheduler #(.DATA_W(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .dec_sel   (dec_sel),
        .dec_en    (dec_en),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic check_outs(input string nm, input logic [3:0] eack, input logic een,
                              input logic [2:0] esel, input logic [7:0] edat, input logic ebusy);
        chk({nm, ".ack"}, {28'd0, ack}, {28'd0, eack});
        chk({nm, ".dec_en"}, {31'd0, dec_en}, {31'd0, een});
        chk({nm, ".clr_busy"}, {31'd0, clr_busy}, {31'd0, ebusy});
        if (een) begin
            chk({nm, ".dec_sel"}, {29'd0, dec_sel}, {29'd0, esel});
            chk({nm, ".wr_data"}, {24'd0, wr_data}, {24'd0, edat});
        end
    endtask

    task automatic step(input string nm, input logic [3:0] r, input logic c, input logic [3:0] eack,
                        input logic een, input logic [2:0] esel, input logic [7:0] edat, input logic ebusy);
        req       = r;
        clr_start = c;
        @(posedge clk);
        #1;
        check_outs(nm, eack, een, esel, edat, ebusy);
    endtask

    function automatic void add(input logic [3:0] r, input logic c, input logic [3:0] a, input logic e,
                                input logic [2:0] s, input logic [7:0] d, input logic b);
        vec_t v;
        v.req = r; v.clr = c; v.ack = a; v.en = e; v.sel = s; v.dat = d; v.busy = b;
        tbl.push_back(v);
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        // requester addr/data: r0=5/A5, r1=2/3C, r2=7/96, r3=1/F0
        req_addr  = {3'd1, 3'd7, 3'd2, 3'd5};
        req_data  = {8'hF0, 8'h96, 8'h3C, 8'hA5};
        req       = 4'b0000;
        clr_start = 1'b0;
        rst_n     = 1'b0;

        // round robin after reset, each requester drops after its ack
        add(4'b1111, 1'b0, 4'b0001, 1'b1, 3'd5, 8'hA5, 1'b0);
        add(4'b1110, 1'b0, 4'b0010, 1'b1, 3'd2, 8'h3C, 1'b0);
        add(4'b1100, 1'b0, 4'b0100, 1'b1, 3'd7, 8'h96, 1'b0);
        add(4'b1000, 1'b0, 4'b1000, 1'b1, 3'd1, 8'hF0, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        // single write then drop
        add(4'b0001, 1'b0, 4'b0001, 1'b1, 3'd5, 8'hA5, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        // hogging requester 1; lone holder is masked for one cycle then re-granted
        add(4'b0010, 1'b0, 4'b0010, 1'b1, 3'd2, 8'h3C, 1'b0);
        add(4'b0010, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        add(4'b0010, 1'b0, 4'b0010, 1'b1, 3'd2, 8'h3C, 1'b0);
        add(4'b0110, 1'b0, 4'b0100, 1'b1, 3'd7, 8'h96, 1'b0);
        add(4'b0010, 1'b0, 4'b0010, 1'b1, 3'd2, 8'h3C, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        // clear from IDLE, with a second clr_start at the third clear cycle
        for (int i = 0; i < 8; i++)
            add(4'b0000, (i == 0 || i == 3), 4'b0000, 1'b1, 3'(i), 8'h00, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        // clear and request collide: clear first, request in the 9th cycle
        for (int i = 0; i < 8; i++)
            add(4'b0100, (i == 0), 4'b0000, 1'b1, 3'(i), 8'h00, 1'b1);
        add(4'b0100, 1'b0, 4'b0100, 1'b1, 3'd7, 8'h96, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        // clr_start during a WRITE cycle
        add(4'b1000, 1'b0, 4'b1000, 1'b1, 3'd1, 8'hF0, 1'b0);
        for (int i = 0; i < 8; i++)
            add(4'b0000, (i == 0), 4'b0000, 1'b1, 3'(i), 8'h00, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("reset.dec_sel", {29'd0, dec_sel}, 32'd0);
        chk("reset.wr_data", {24'd0, wr_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].clr, tbl[i].ack,
                 tbl[i].en, tbl[i].sel, tbl[i].dat, tbl[i].busy);

        // reset mid-clear: move ptr to 1 first so a reset ptr is observable
        step("pre.w1", 4'b0010, 1'b0, 4'b0010, 1'b1, 3'd2, 8'h3C, 1'b0);
        step("pre.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        step("mclr0", 4'b0000, 1'b1, 4'b0000, 1'b1, 3'd0, 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++)
            step($sformatf("mclr%0d", i), 4'b0000, 1'b0, 4'b0000, 1'b1, 3'(i), 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("async_rst.dec_sel", {29'd0, dec_sel}, 32'd0);
        chk("async_rst.wr_data", {24'd0, wr_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        step("post.ptr", 4'b0110, 1'b0, 4'b0010, 1'b1, 3'd2, 8'h3C, 1'b0);
        step("post.r2", 4'b0100, 1'b0, 4'b0100, 1'b1, 3'd7, 8'h96, 1'b0);
        step("post.idle2", 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        step("post.r3", 4'b1000, 1'b0, 4'b1000, 1'b1, 3'd1, 8'hF0, 1'b0);
        step("post.idle3", 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);
        step("post.r0first", 4'b1001, 1'b0, 4'b0001, 1'b1, 3'd5, 8'hA5, 1'b0);
        step("post.r3next", 4'b1000, 1'b0, 4'b1000, 1'b1, 3'd1, 8'hF0, 1'b0);
        step("post.end", 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
